// File: rtl/bnn_fc_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bnn_fc_seq_if
// Purpose  : Handshake/data bundle for bnn_fc_seq; raw_score exists only when
//            BNN_FC_RAW_OUT_EN is defined.
// Revision : 1.0
// ============================================================================
interface bnn_fc_seq_if #(
    parameter int ISIZE    = 16,
    parameter int LSIZE    = 10,
    parameter int THRESH_W = 16
);
    localparam int CNT_W = $clog2(ISIZE + 1) + 2;

    logic                      in_valid;
    logic                      in_ready;
    logic [ISIZE-1:0]          in_vec;
    logic [LSIZE*ISIZE-1:0]    w_bits;
    logic [LSIZE*ISIZE-1:0]    w_mask;
    logic [LSIZE*THRESH_W-1:0] threshold;
    logic                      out_valid;
    logic                      out_ready;
    logic [LSIZE-1:0]          o;
    logic                      busy;
`ifdef BNN_FC_RAW_OUT_EN
    logic [LSIZE*CNT_W-1:0]    raw_score;

    modport master (
        output in_valid, in_vec, w_bits, w_mask, threshold, out_ready,
        input  in_ready, out_valid, o, busy, raw_score
    );
    modport slave (
        input  in_valid, in_vec, w_bits, w_mask, threshold, out_ready,
        output in_ready, out_valid, o, busy, raw_score
    );
`else
    modport master (
        output in_valid, in_vec, w_bits, w_mask, threshold, out_ready,
        input  in_ready, out_valid, o, busy
    );
    modport slave (
        input  in_valid, in_vec, w_bits, w_mask, threshold, out_ready,
        output in_ready, out_valid, o, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/bnn_fc_seq.sv
`default_nettype none
// ============================================================================
// Module   : bnn_fc_seq
// Purpose  : Time-multiplexed binarised FC layer with sparse weight masks,
//            CHUNK input bits per clock. BNN_FC_RAW_OUT_EN adds raw_score.
// Revision : 1.0
// ============================================================================
module bnn_fc_seq #(
    parameter int ISIZE    = 16,
    parameter int LSIZE    = 10,
    parameter int CHUNK    = 4,
    parameter int THRESH_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    bnn_fc_seq_if.slave bus
);
    localparam int NCHUNK = (ISIZE + CHUNK - 1) / CHUNK;
    localparam int CNT_W  = $clog2(ISIZE + 1) + 2;
    localparam int PADW   = NCHUNK * CHUNK;
    localparam int NW     = (LSIZE > 1) ? $clog2(LSIZE) : 1;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PC_W   = $clog2(CHUNK + 1);
    localparam int CMP_W  = ((CNT_W > THRESH_W) ? CNT_W : THRESH_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ISIZE-1:0]          vec_q;
    logic [LSIZE*ISIZE-1:0]    wb_q;
    logic [LSIZE*ISIZE-1:0]    wm_q;
    logic [LSIZE*THRESH_W-1:0] th_q;
    logic [NW-1:0]             n_q;
    logic [CW-1:0]             c_q;
    logic [CNT_W-1:0]          acc_q;
    logic [CNT_W-1:0]          nv_q;
    logic [LSIZE-1:0]          o_q;

    logic                       accept;
    logic                       last_chunk;
    logic                       last_neuron;
    logic [PADW-1:0]            match_pad;
    logic [PADW-1:0]            mask_pad;
    logic [CHUNK-1:0]           match_chunk;
    logic [CHUNK-1:0]           mask_chunk;
    logic [PC_W-1:0]            match_cnt;
    logic [PC_W-1:0]            mask_cnt;
    logic [CNT_W-1:0]           acc_nxt;
    logic [CNT_W-1:0]           nv_nxt;
    logic signed [THRESH_W-1:0] th_n;
    logic signed [CMP_W-1:0]    lhs;
    logic signed [CMP_W-1:0]    rhs;
    logic                       fire;

    assign last_chunk  = (c_q == CW'(NCHUNK - 1));
    assign last_neuron = (n_q == NW'(LSIZE - 1));

    // Pad bits beyond ISIZE stay zero in both vectors, so a ragged last chunk
    // contributes nothing to either count.
    always_comb begin
        match_pad = '0;
        mask_pad  = '0;
        mask_pad[ISIZE-1:0]  = wm_q[n_q*ISIZE +: ISIZE];
        match_pad[ISIZE-1:0] = ~(vec_q ^ wb_q[n_q*ISIZE +: ISIZE])
                               & wm_q[n_q*ISIZE +: ISIZE];
        match_chunk = match_pad[c_q*CHUNK +: CHUNK];
        mask_chunk  = mask_pad[c_q*CHUNK +: CHUNK];
        match_cnt   = '0;
        mask_cnt    = '0;
        for (int k = 0; k < CHUNK; k++) begin
            match_cnt = match_cnt + PC_W'(match_chunk[k]);
            mask_cnt  = mask_cnt + PC_W'(mask_chunk[k]);
        end
        acc_nxt = acc_q + CNT_W'(match_cnt);
        nv_nxt  = nv_q + CNT_W'(mask_cnt);
        th_n    = th_q[n_q*THRESH_W +: THRESH_W];
        // 2*acc is non-negative and narrower than CMP_W; threshold is sign-extended.
        lhs  = $signed(CMP_W'({acc_nxt, 1'b0}));
        rhs  = CMP_W'(th_n) + $signed(CMP_W'(nv_nxt));
        fire = (lhs > rhs);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.busy      = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                bus.busy = 1'b1;
                if (last_chunk && last_neuron) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vec_q <= '0;
            wb_q  <= '0;
            wm_q  <= '0;
            th_q  <= '0;
            n_q   <= '0;
            c_q   <= '0;
            acc_q <= '0;
            nv_q  <= '0;
            o_q   <= '0;
        end else if (accept) begin
            vec_q <= bus.in_vec;
            wb_q  <= bus.w_bits;
            wm_q  <= bus.w_mask;
            th_q  <= bus.threshold;
            n_q   <= '0;
            c_q   <= '0;
            acc_q <= '0;
            nv_q  <= '0;
        end else if (state == S_RUN) begin
            if (last_chunk) begin
                o_q[n_q] <= fire;
                c_q      <= '0;
                acc_q    <= '0;
                nv_q     <= '0;
                n_q      <= last_neuron ? '0 : n_q + NW'(1);
            end else begin
                c_q   <= c_q + CW'(1);
                acc_q <= acc_nxt;
                nv_q  <= nv_nxt;
            end
        end
    end

    assign bus.o = o_q;

`ifdef BNN_FC_RAW_OUT_EN
    logic [CNT_W-1:0]       score;
    logic [LSIZE*CNT_W-1:0] raw_q;

    assign score = {acc_nxt[CNT_W-2:0], 1'b0} - nv_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw_q <= '0;
        end else if (state == S_RUN && last_chunk) begin
            raw_q[n_q*CNT_W +: CNT_W] <= score;
        end
    end

    assign bus.raw_score = raw_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bnn_fc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bnn_fc_seq
// Purpose  : Self-checking bench for bnn_fc_seq: per-cycle behavioural model
//            compare plus directed literal cases (raw_score if BNN_FC_RAW_OUT_EN).
// Revision : 1.0
// ============================================================================
module tb_bnn_fc_seq;
    localparam int ISIZE  = 16;
    localparam int LSIZE  = 10;
    localparam int CHUNK  = 4;
    localparam int TW     = 16;
    localparam int NCHUNK = (ISIZE + CHUNK - 1) / CHUNK;
    localparam int CNT_W  = $clog2(ISIZE + 1) + 2;
    localparam int LAT    = LSIZE * NCHUNK;
    localparam int ISIZE2 = 10;
    localparam int CNT_W2 = $clog2(ISIZE2 + 1) + 2;
    localparam int LAT2   = LSIZE * ((ISIZE2 + CHUNK - 1) / CHUNK);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc   = 0;

    bnn_fc_seq_if #(.ISIZE(ISIZE),  .LSIZE(LSIZE), .THRESH_W(TW)) bus ();
    bnn_fc_seq_if #(.ISIZE(ISIZE2), .LSIZE(LSIZE), .THRESH_W(TW)) bus2 ();

    bnn_fc_seq #(.ISIZE(ISIZE),  .LSIZE(LSIZE), .CHUNK(CHUNK), .THRESH_W(TW))
        dut  (.clk(clk), .rst(rst), .bus(bus));
    bnn_fc_seq #(.ISIZE(ISIZE2), .LSIZE(LSIZE), .CHUNK(CHUNK), .THRESH_W(TW))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: count agreements among present weights, then compare 2a > t + m.
    function automatic void model(input logic [ISIZE-1:0] v,
                                  input logic [LSIZE*ISIZE-1:0] wb,
                                  input logic [LSIZE*ISIZE-1:0] wm,
                                  input logic [LSIZE*TW-1:0] th,
                                  output logic [LSIZE-1:0] eo,
                                  output logic [LSIZE*CNT_W-1:0] er);
        eo = '0;
        er = '0;
        for (int n = 0; n < LSIZE; n++) begin
            int a;
            int m;
            int t;
            logic signed [TW-1:0] ts;
            a = 0;
            m = 0;
            for (int j = 0; j < ISIZE; j++) begin
                if (wm[n*ISIZE+j]) begin
                    m++;
                    if (v[j] == wb[n*ISIZE+j]) a++;
                end
            end
            ts = th[n*TW +: TW];
            t  = int'(ts);
            eo[n] = (2 * a > t + m);
            er[n*CNT_W +: CNT_W] = CNT_W'(2 * a - m);
        end
    endfunction

    function automatic logic [LSIZE*ISIZE-1:0] rand_bits();
        logic [LSIZE*ISIZE-1:0] r;
        for (int i = 0; i < LSIZE*ISIZE; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic logic [LSIZE*TW-1:0] rand_th();
        logic [LSIZE*TW-1:0] r;
        for (int n = 0; n < LSIZE; n++) begin
            int t;
            t = int'($urandom_range(0, 40)) - 20;
            r[n*TW +: TW] = TW'(t);
        end
        return r;
    endfunction

    function automatic int slice_s(input logic [LSIZE*CNT_W-1:0] r, input int n);
        logic signed [CNT_W-1:0] s;
        s = r[n*CNT_W +: CNT_W];
        return int'(s);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle compare against the model; a transaction is outstanding from
    // its accept edge until the out_valid/out_ready handshake.
    logic                   pend    = 1'b0;
    longint                 acc_cyc = 0;
    logic [LSIZE-1:0]       exp_o;
    logic [LSIZE*CNT_W-1:0] exp_raw;
    logic                   dn;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            pend = 1'b0;
            check("rst_in_ready", bus.in_ready, 1);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_o", bus.o, 0);
`ifdef BNN_FC_RAW_OUT_EN
            for (int n = 0; n < LSIZE; n++) check("rst_raw", slice_s(bus.raw_score, n), 0);
`endif
        end else begin
            dn = pend && (cyc - acc_cyc >= LAT);
            check("in_ready", bus.in_ready, !pend);
            check("busy", bus.busy, pend && !dn);
            check("out_valid", bus.out_valid, dn);
            if (dn) begin
                check("o", bus.o, exp_o);
`ifdef BNN_FC_RAW_OUT_EN
                for (int n = 0; n < LSIZE; n++)
                    check("raw", slice_s(bus.raw_score, n), slice_s(exp_raw, n));
`endif
                if (bus.out_ready) pend = 1'b0;
            end else if (!pend && bus.in_valid) begin
                model(bus.in_vec, bus.w_bits, bus.w_mask, bus.threshold, exp_o, exp_raw);
                pend    = 1'b1;
                acc_cyc = cyc + 1;
            end
        end
    end

    logic [LSIZE-1:0]       got_o;
    logic [LSIZE*CNT_W-1:0] got_raw;
    int                     got_lat;

    task automatic do_txn(input logic [ISIZE-1:0] v, input logic [LSIZE*ISIZE-1:0] wb,
                          input logic [LSIZE*ISIZE-1:0] wm, input logic [LSIZE*TW-1:0] th,
                          input int stall, input bit noise);
        int k;
        bit seen;
        logic [LSIZE-1:0] held;
        bus.in_vec    = v;
        bus.w_bits    = wb;
        bus.w_mask    = wm;
        bus.threshold = th;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        k    = 0;
        seen = 1'b0;
        while (k < 400 && !seen) begin
            @(posedge clk); #1;
            k++;
            if (bus.out_valid) begin
                seen = 1'b1;
            end else if (noise) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.in_vec    = ISIZE'($urandom);
                bus.w_bits    = rand_bits();
                bus.w_mask    = rand_bits();
                bus.threshold = rand_th();
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        got_lat = k - 1;
        if (!seen) check("out_valid_timeout", bus.out_valid, 1);
        held = bus.o;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        if (stall > 0) begin
            check("stall_valid", bus.out_valid, 1);
            check("stall_hold", bus.o, held);
        end
        got_o = bus.o;
`ifdef BNN_FC_RAW_OUT_EN
        got_raw = bus.raw_score;
`else
        got_raw = '0;
`endif
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [LSIZE*TW-1:0] th;
        int k;

        bus.in_valid   = 1'b0;
        bus.in_vec     = '0;
        bus.w_bits     = '0;
        bus.w_mask     = '0;
        bus.threshold  = '0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_vec    = '0;
        bus2.w_bits    = '0;
        bus2.w_mask    = '0;
        bus2.threshold = '0;
        bus2.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1);
        check("idle_o", bus.o, 0);
        @(posedge clk); #1;

        // All agree, all present: every neuron fires, score = +16.
        do_txn('1, '1, '1, '0, 0, 0);
        check("t1_latency", got_lat, LAT);
        check("t1_o", got_o, 10'h3FF);
`ifdef BNN_FC_RAW_OUT_EN
        for (int n = 0; n < LSIZE; n++) check("t1_raw", slice_s(got_raw, n), 16);
`endif

        // All disagree: score = -16, nothing fires.
        do_txn('1, '0, '1, '0, 0, 0);
        check("t2_o", got_o, 10'h000);
`ifdef BNN_FC_RAW_OUT_EN
        for (int n = 0; n < LSIZE; n++) check("t2_raw", slice_s(got_raw, n), -16);
`endif

        // Empty masks: only the neuron with a negative threshold fires.
        th = '0;
        th[3*TW +: TW] = '1;
        do_txn('1, '1, '0, th, 0, 0);
        check("t3_o", got_o, 10'h008);
`ifdef BNN_FC_RAW_OUT_EN
        for (int n = 0; n < LSIZE; n++) check("t3_raw", slice_s(got_raw, n), 0);
`endif

        // Extreme thresholds: most-negative fires, most-positive never does.
        for (int n = 0; n < LSIZE; n++) th[n*TW +: TW] = (n % 2 == 0) ? 16'h8000 : 16'h7FFF;
        do_txn('1, '1, '1, th, 0, 0);
        check("t4_o", got_o, 10'h155);

        // Output stall with noisy inputs during RUN.
        do_txn(ISIZE'($urandom), rand_bits(), rand_bits(), rand_th(), 5, 1);
        check("t5_latency", got_lat, LAT);

        for (int i = 0; i < 24; i++) begin
            logic [LSIZE*ISIZE-1:0] wm;
            wm = (i % 3 == 0) ? (rand_bits() & rand_bits()) : rand_bits();
            do_txn(ISIZE'($urandom), rand_bits(), wm, rand_th(),
                   int'($urandom_range(0, 3)), 1'(i % 2));
        end

        // Reset in the middle of RUN abandons the transaction.
        bus.in_vec    = ISIZE'($urandom);
        bus.w_bits    = rand_bits();
        bus.w_mask    = rand_bits();
        bus.threshold = rand_th();
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        check("mid_busy", bus.busy, 1);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", bus.out_valid, 0);
        check("post_rst_o", bus.o, 0);
        check("post_rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        do_txn('1, '1, '1, '0, 0, 0);
        check("post_rst_latency", got_lat, LAT);
        check("post_rst_o_final", got_o, 10'h3FF);

        // ISIZE=10 with CHUNK=4: ragged last chunk, no extra cycles.
        for (int p = 0; p < 2; p++) begin
            bus2.in_vec    = '1;
            bus2.w_bits    = (p == 0) ? '1 : '0;
            bus2.w_mask    = '1;
            bus2.threshold = '0;
            bus2.in_valid  = 1'b1;
            bus2.out_ready = 1'b0;
            k = 0;
            while (k < 400 && !bus2.out_valid) begin
                @(posedge clk); #1;
                k++;
                bus2.in_valid = 1'b0;
            end
            check("odd_latency", k - 1, LAT2);
            check("odd_o", bus2.o, (p == 0) ? 10'h3FF : 10'h000);
`ifdef BNN_FC_RAW_OUT_EN
            for (int n = 0; n < LSIZE; n++) begin
                logic signed [CNT_W2-1:0] s2;
                s2 = bus2.raw_score[n*CNT_W2 +: CNT_W2];
                check("odd_raw", int'(s2), (p == 0) ? 10 : -10);
            end
`endif
            bus2.out_ready = 1'b1;
            @(posedge clk); #1;
            bus2.out_ready = 1'b0;
            check("odd_back_idle", bus2.in_ready, 1);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bnn_fc_seq.md
Name: bnn_fc_seq

Overview:
- Sequential, time-multiplexed binarised fully-connected layer with sparse per-weight masks.
- Consumes one input bit-vector per transaction and evaluates LSIZE neurons, CHUNK input bits per clock, with one shared XNOR/popcount datapath.
- Mask and per-neuron thresholds are run-time inputs, not elaboration constants, so one instance serves any layer of matching dimensions.
- Sits between a binarised activation producer and the next layer, with valid/ready handshakes on both sides.

Parameters:
- ISIZE, 16, input vector width (bits per neuron).
- LSIZE, 10, number of output neurons.
- CHUNK, 4, input bits processed per cycle; 1 <= CHUNK <= ISIZE.
- THRESH_W, 16, signed threshold width per neuron.
- NCHUNK, derived ceil(ISIZE/CHUNK), chunks per neuron; not user-set.
- CNT_W, derived $clog2(ISIZE+1)+2, signed score width; not user-set.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_vec  in  ISIZE  input activation bits.
- w_bits  in  LSIZE*ISIZE  weight bits; neuron n, bit j at index n*ISIZE+j.
- w_mask  in  LSIZE*ISIZE  1 = weight present; same indexing as w_bits.
- threshold  in  LSIZE*THRESH_W  signed per-neuron threshold; neuron n at slice n.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- o  out  LSIZE  neuron output bits.
- busy  out  1  high in RUN.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - o=0, out_valid=0, busy=0, in_ready=1.
  - All counters and accumulators cleared.
- Reset mid-RUN or mid-DONE: the current transaction is abandoned and no out_valid pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, register in_vec, w_bits, w_mask and threshold; neuron index n=0, chunk index c=0, acc=0, nv=0; go to RUN.
- RUN (one chunk per cycle):
  - Chunk c covers bits j = c*CHUNK .. c*CHUNK+CHUNK-1.
  - acc += popcount over the chunk of ((in_vec[j] XNOR w_bits[n,j]) AND w_mask[n,j]).
  - nv += popcount of w_mask[n,j] over the chunk.
  - Bits with j >= ISIZE in the last chunk are forced masked-out.
- End of neuron (c = NCHUNK-1):
  - score = 2*acc_final - nv_final, signed CNT_W.
  - o[n] = (2*acc_final > threshold[n] + nv_final).
  - Comparison is signed, at width max(CNT_W,THRESH_W)+1, so it cannot overflow.
  - Then c=0, acc=0, nv=0, n++.
- After the last chunk of neuron LSIZE-1: go to DONE.
- Latency: exactly LSIZE*NCHUNK cycles in RUN; out_valid rises on the edge after the final chunk.
- DONE:
  - out_valid=1.
  - o and optional outputs held stable until out_ready is sampled high; then return to IDLE.
  - in_ready=0 in DONE, so no back-to-back overlap; the next transaction is accepted no earlier than the cycle after the IDLE return.
- Inputs in RUN/DONE:
  - in_valid is ignored.
  - Registered copies are used, so changes to w_bits, w_mask and threshold have no effect.
- o bits for neurons not yet evaluated hold their previous transaction value until overwritten; the full vector is only defined while out_valid=1.
- Neuron with all mask bits zero: acc=0, nv=0, so o[n] = (0 > threshold[n]), i.e. 1 iff threshold is negative.
- ISIZE not divisible by CHUNK: handled by masking, with no extra cycles.

Optional Feature:
- Macro: BNN_FC_RAW_OUT_EN.
- Defined:
  - Adds output port raw_score, LSIZE*CNT_W, holding signed score (2*acc - nv) for neuron n at slice n.
  - Written at the same edge as o[n]; held with o in DONE; reset to 0.
- Undefined:
  - Port absent; no score storage registers.
  - o behaviour identical.

Test Plan:
- Defaults. All mask=1, in_vec=16'hFFFF, all w_bits=1, thresholds 0 -> out_valid exactly 40 cycles after handshake, o=10'h3FF, raw_score=16 per neuron.
- Same as above but all w_bits=0 -> o=10'h000, raw_score=-16 each.
- All mask=0, threshold[3]=-1, others 0 -> o=10'h008, raw_score=0 each.
- ISIZE=10, CHUNK=4, mask=1, in_vec all 1, w_bits all 1, threshold 0 -> latency 30 cycles, o=10'h3FF, raw_score=10 each; bits j=10,11 have no effect.
- Handshake stall:
  - out_ready low for 5 cycles in DONE -> out_valid and o held constant throughout.
  - in_valid pulses during RUN -> not accepted, in_ready=0.
- Reset mid-transaction: rst low at RUN cycle 12 for 2 cycles -> out_valid=0, o=0, in_ready=1 after release; a new vector then completes with correct o after 40 cycles.
